// File: rtl/pong_match_ctrl.sv
// Pong match controller: N-player scoring, round timer, serve delay and pause/resume.
// Optional PONG_SPEEDUP_EN adds a play-seconds counter that steps speed_level.
module pong_match_ctrl #(
  parameter int NUM_PLAYERS = 2,
  parameter int SCORE_W     = 3,
  parameter int WIN_SCORE   = 7,
  parameter int ROUND_SECS  = 180,
  parameter int SERVE_SECS  = 2,
  parameter int TIME_W      = 8
`ifdef PONG_SPEEDUP_EN
  ,
  parameter int SPEEDUP_SECS = 10
`endif
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           tick_1hz,
  input  logic                           start,
  input  logic                           pause,
  input  logic [NUM_PLAYERS-1:0]         miss,
  output logic [2:0]                     state,
  output logic                           stop,
  output logic                           serve_pulse,
  output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
  output logic [TIME_W-1:0]              time_left,
  output logic [1:0]                     winner,
  output logic                           winner_valid,
  output logic                           tie,
  output logic [1:0]                     speed_level
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SERVE  = 3'd1,
    S_PLAY   = 3'd2,
    S_PAUSED = 3'd3,
    S_OVER   = 3'd4
  } state_t;

  localparam int SRV_W = (SERVE_SECS > 0) ? $clog2(SERVE_SECS + 1) : 1;
  localparam logic [SCORE_W-1:0] WIN_V = SCORE_W'(WIN_SCORE);

  state_t                           state_q, state_d;
  logic [SRV_W-1:0]                 serve_cnt_q, serve_cnt_d;
  logic [NUM_PLAYERS*SCORE_W-1:0]   scores_d;
  logic [TIME_W-1:0]                time_d;
  logic [1:0]                       winner_d;
  logic                             tie_d;
  logic                             serve_pulse_d;
  logic                             expire;
  logic                             miss_seen;
  logic [1:0]                       miss_idx;
  logic                             win_hit;
  logic [SCORE_W-1:0]               best;
  logic [SCORE_W-1:0]               s;

  always_comb begin
    state_d       = state_q;
    serve_cnt_d   = serve_cnt_q;
    scores_d      = scores;
    time_d        = time_left;
    winner_d      = winner;
    tie_d         = tie;
    serve_pulse_d = 1'b0;
    expire        = 1'b0;
    miss_seen     = 1'b0;
    miss_idx      = 2'd0;
    win_hit       = 1'b0;
    best          = '0;
    s             = '0;

    case (state_q)
      S_IDLE: begin
        scores_d = '0;
        time_d   = TIME_W'(ROUND_SECS);
        if (start) begin
          state_d     = S_SERVE;
          serve_cnt_d = SRV_W'(SERVE_SECS);
        end
      end
      S_SERVE: begin
        if (serve_cnt_q == '0) begin
          state_d       = S_PLAY;
          serve_pulse_d = 1'b1;
        end else if (tick_1hz) begin
          serve_cnt_d = serve_cnt_q - SRV_W'(1);
        end
      end
      S_PLAY: begin
        if (ROUND_SECS != 0 && tick_1hz && time_left != '0) begin
          time_d = time_left - TIME_W'(1);
          expire = (time_d == '0);
        end
        if (|miss) begin
          // Only the lowest-index miss counts; everyone else scores a point.
          for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (!miss_seen && miss[i]) begin
              miss_seen = 1'b1;
              miss_idx  = 2'(i);
            end
          end
          for (int i = 0; i < NUM_PLAYERS; i++) begin
            s = scores[i*SCORE_W +: SCORE_W];
            if (2'(i) != miss_idx && s < WIN_V) s = s + SCORE_W'(1);
            scores_d[i*SCORE_W +: SCORE_W] = s;
            if (s == WIN_V) win_hit = 1'b1;
          end
          if (win_hit || expire) begin
            state_d = S_OVER;
          end else begin
            state_d     = S_SERVE;
            serve_cnt_d = SRV_W'(SERVE_SECS);
          end
        end else if (expire) begin
          state_d = S_OVER;
        end else if (pause) begin
          state_d = S_PAUSED;
        end
      end
      S_PAUSED: begin
        if (pause) state_d = S_PLAY;
      end
      S_OVER: begin
        if (start) begin
          state_d  = S_IDLE;
          scores_d = '0;
          time_d   = TIME_W'(ROUND_SECS);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Result is latched from the final scores on OVER entry and held until leaving OVER.
    if (state_d == S_OVER && state_q != S_OVER) begin
      best     = scores_d[SCORE_W-1:0];
      winner_d = 2'd0;
      tie_d    = 1'b0;
      for (int i = 1; i < NUM_PLAYERS; i++) begin
        s = scores_d[i*SCORE_W +: SCORE_W];
        if (s > best) begin
          best     = s;
          winner_d = 2'(i);
          tie_d    = 1'b0;
        end else if (s == best) begin
          tie_d = 1'b1;
        end
      end
    end else if (state_d != S_OVER) begin
      winner_d = 2'd0;
      tie_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      serve_cnt_q  <= '0;
      stop         <= 1'b1;
      serve_pulse  <= 1'b0;
      scores       <= '0;
      time_left    <= TIME_W'(ROUND_SECS);
      winner       <= 2'd0;
      winner_valid <= 1'b0;
      tie          <= 1'b0;
    end else begin
      state_q      <= state_d;
      serve_cnt_q  <= serve_cnt_d;
      stop         <= (state_d != S_PLAY);
      serve_pulse  <= serve_pulse_d;
      scores       <= scores_d;
      time_left    <= time_d;
      winner       <= winner_d;
      winner_valid <= (state_d == S_OVER);
      tie          <= tie_d;
    end
  end

  assign state = state_q;

`ifdef PONG_SPEEDUP_EN
  localparam int PS_W = $clog2(SPEEDUP_SECS + 1);
  logic [PS_W-1:0] play_secs;
  logic            serve_entry;

  assign serve_entry = (state_d == S_SERVE) && (state_q != S_SERVE);

  always_ff @(posedge clk) begin
    if (rst || serve_entry) begin
      play_secs   <= '0;
      speed_level <= 2'd0;
    end else if (state_q == S_PLAY && tick_1hz) begin
      if (play_secs == PS_W'(SPEEDUP_SECS - 1)) begin
        play_secs <= '0;
        if (speed_level != 2'd3) speed_level <= speed_level + 2'd1;
      end else begin
        play_secs <= play_secs + PS_W'(1);
      end
    end
  end
`else
  assign speed_level = 2'd0;
`endif

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Scoreboard bench: a timed DUT and an untimed (ROUND_SECS=0, SERVE_SECS=0) DUT.
module tb_pong_match_ctrl;

`ifdef PONG_SPEEDUP_EN
  localparam int SPD_ON = 1;
`else
  localparam int SPD_ON = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0, start = 1'b0, pause = 1'b0;
  logic [1:0] miss = 2'b00;
  logic u_tick = 1'b0, u_start = 1'b0, u_pause = 1'b0;
  logic [1:0] u_miss = 2'b00;

  logic [2:0] state, u_state;
  logic       stop, u_stop, sp, u_sp, wv, u_wv, tie, u_tie;
  logic [5:0] scores, u_scores;
  logic [7:0] tl, u_tl;
  logic [1:0] win, u_win, spd, u_spd;

  always #5 clk = ~clk;

  pong_match_ctrl #(.NUM_PLAYERS(2), .SCORE_W(3), .WIN_SCORE(3), .ROUND_SECS(5),
                    .SERVE_SECS(2), .TIME_W(8)) u_dut (
    .clk(clk), .rst(rst), .tick_1hz(tick), .start(start), .pause(pause), .miss(miss),
    .state(state), .stop(stop), .serve_pulse(sp), .scores(scores), .time_left(tl),
    .winner(win), .winner_valid(wv), .tie(tie), .speed_level(spd));

  pong_match_ctrl #(.NUM_PLAYERS(2), .SCORE_W(3), .WIN_SCORE(3), .ROUND_SECS(0),
                    .SERVE_SECS(0), .TIME_W(8)
`ifdef PONG_SPEEDUP_EN
                    , .SPEEDUP_SECS(2)
`endif
                   ) u_untimed (
    .clk(clk), .rst(rst), .tick_1hz(u_tick), .start(u_start), .pause(u_pause), .miss(u_miss),
    .state(u_state), .stop(u_stop), .serve_pulse(u_sp), .scores(u_scores), .time_left(u_tl),
    .winner(u_win), .winner_valid(u_wv), .tie(u_tie), .speed_level(u_spd));

  typedef struct {
    string      name;
    bit         u;
    logic [2:0] st;
    logic       stop;
    logic       sp;
    logic [5:0] sc;
    logic [7:0] tl;
    logic [1:0] win;
    logic       wv;
    logic       tie;
    logic [1:0] spd;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Monitor: compares every queued expectation against the DUT on the falling edge.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [32:0] got, req;
      e = q.pop_front();
      if (e.u) got = {u_state, u_stop, u_sp, u_scores, u_tl, u_win, u_wv, u_tie, u_spd};
      else     got = {state, stop, sp, scores, tl, win, wv, tie, spd};
      req = {e.st, e.stop, e.sp, e.sc, e.tl, e.win, e.wv, e.tie, e.spd};
      checks++;
      if (got !== req) begin
        errors++;
        $display("FAIL %s: got st=%0d stop=%b sp=%b sc=%h tl=%0d win=%0d wv=%b tie=%b spd=%0d, expected st=%0d stop=%b sp=%b sc=%h tl=%0d win=%0d wv=%b tie=%b spd=%0d",
                 e.name, got[32:30], got[29], got[28], got[27:22], got[21:14], got[13:12], got[11], got[10], got[9:8],
                 e.st, e.stop, e.sp, e.sc, e.tl, e.win, e.wv, e.tie, e.spd);
      end
    end
  end

  task automatic cyc(input bit u, input bit t, input bit s, input bit p, input logic [1:0] m);
    if (u) begin u_tick = t; u_start = s; u_pause = p; u_miss = m; end
    else   begin tick = t;   start = s;   pause = p;   miss = m;   end
    @(posedge clk);
    #1;
    tick = 0; start = 0; pause = 0; miss = 2'b00;
    u_tick = 0; u_start = 0; u_pause = 0; u_miss = 2'b00;
  endtask

  task automatic expect_st(input bit u, input string name, input logic [2:0] st, input bit spv,
                           input int p0, input int p1, input int t, input int w, input bit wvv,
                           input bit tiev, input int sl);
    exp_t e;
    e.name = name; e.u = u; e.st = st; e.stop = (st != 3'd2); e.sp = spv;
    e.sc = {3'(p1), 3'(p0)}; e.tl = 8'(t); e.win = 2'(w); e.wv = wvv; e.tie = tiev; e.spd = 2'(sl);
    q.push_back(e);
  endtask

  // Two serve ticks, then the cycle where serve_cnt reads 0 moves to PLAY.
  task automatic to_play(input int p0, input int p1, input int t);
    cyc(0, 1, 0, 0, 2'b00);
    cyc(0, 1, 0, 0, 2'b00);
    expect_st(0, "serve_wait", 3'd1, 0, p0, p1, t, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 2'b00);
    expect_st(0, "serve_to_play", 3'd2, 1, p0, p1, t, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    cyc(0, 0, 0, 0, 2'b00);
    cyc(0, 0, 0, 0, 2'b00);
    expect_st(0, "reset", 3'd0, 0, 0, 0, 5, 0, 0, 0, 0);
    expect_st(1, "reset_untimed", 3'd0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    cyc(0, 1, 0, 1, 2'b11);
    expect_st(0, "idle_ignores", 3'd0, 0, 0, 0, 5, 0, 0, 0, 0);

    // Start, serve delay, first point, play to WIN_SCORE.
    cyc(0, 0, 1, 0, 2'b00);
    expect_st(0, "start_serve", 3'd1, 0, 0, 0, 5, 0, 0, 0, 0);
    to_play(0, 0, 5);
    cyc(0, 0, 0, 0, 2'b00);
    expect_st(0, "pulse_one_cycle", 3'd2, 0, 0, 0, 5, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 2'b01);
    expect_st(0, "miss_p0_1", 3'd1, 0, 0, 1, 5, 0, 0, 0, 0);
    to_play(0, 1, 5);
    cyc(0, 0, 0, 0, 2'b01);
    expect_st(0, "miss_p0_2", 3'd1, 0, 0, 2, 5, 0, 0, 0, 0);
    to_play(0, 2, 5);
    cyc(0, 0, 0, 0, 2'b01);
    expect_st(0, "win_over", 3'd4, 0, 0, 3, 5, 1, 1, 0, 0);
    cyc(0, 1, 0, 1, 2'b10);
    expect_st(0, "over_hold", 3'd4, 0, 0, 3, 5, 1, 1, 0, 0);
    cyc(0, 0, 1, 0, 2'b00);
    expect_st(0, "over_to_idle", 3'd0, 0, 0, 0, 5, 0, 0, 0, 0);

    // Round timer expiry at 0:0.
    cyc(0, 0, 1, 0, 2'b00);
    to_play(0, 0, 5);
    for (int i = 1; i <= 4; i++) begin
      cyc(0, 1, 0, 0, 2'b00);
      expect_st(0, "tick_play", 3'd2, 0, 0, 0, 5 - i, 0, 0, 0, 0);
    end
    cyc(0, 1, 0, 0, 2'b00);
    expect_st(0, "time_up_tie", 3'd4, 0, 0, 0, 0, 0, 1, 1, 0);
    cyc(0, 0, 1, 0, 2'b00);
    expect_st(0, "idle_time_reload", 3'd0, 0, 0, 0, 5, 0, 0, 0, 0);

    // Miss on the final tick: score first, then OVER.
    cyc(0, 0, 1, 0, 2'b00);
    to_play(0, 0, 5);
    for (int i = 1; i <= 4; i++) cyc(0, 1, 0, 0, 2'b00);
    cyc(0, 1, 0, 0, 2'b10);
    expect_st(0, "miss_final_tick", 3'd4, 0, 1, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 2'b00);

    // Pause behaviour and multi-bit miss.
    cyc(0, 0, 1, 0, 2'b00);
    to_play(0, 0, 5);
    cyc(0, 0, 0, 1, 2'b00);
    expect_st(0, "pause", 3'd3, 0, 0, 0, 5, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 2'b00);
    cyc(0, 0, 0, 0, 2'b11);
    cyc(0, 0, 1, 0, 2'b00);
    expect_st(0, "paused_frozen", 3'd3, 0, 0, 0, 5, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 2'b00);
    expect_st(0, "resume_no_pulse", 3'd2, 0, 0, 0, 5, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 2'b11);
    expect_st(0, "miss_both_low_idx", 3'd1, 0, 0, 1, 5, 0, 0, 0, 0);
    to_play(0, 1, 5);
    cyc(0, 0, 0, 1, 2'b10);
    expect_st(0, "miss_beats_pause", 3'd1, 0, 1, 1, 5, 0, 0, 0, 0);

    // Untimed DUT: zero serve delay, time_left pinned at 0, speed steps.
    cyc(1, 0, 1, 0, 2'b00);
    expect_st(1, "u_start", 3'd1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 2'b00);
    expect_st(1, "u_serve0_play", 3'd2, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 2'b00);
    cyc(1, 1, 0, 0, 2'b00);
    expect_st(1, "u_speed1", 3'd2, 0, 0, 0, 0, 0, 0, 0, SPD_ON);
    for (int i = 0; i < 5; i++) cyc(1, 1, 0, 0, 2'b00);
    expect_st(1, "u_speed_sat", 3'd2, 0, 0, 0, 0, 0, 0, 0, 3 * SPD_ON);
    cyc(1, 0, 0, 0, 2'b01);
    expect_st(1, "u_miss_speed_clr", 3'd1, 0, 0, 1, 0, 0, 0, 0, 0);

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
